sysmem_bus_ctrl: RTL

Bridges the PicoRV32 native memory bus to the four 1024x8 byte-lane system-memory BRAMs (one per byte of the 32-bit word, hi lane included). It decodes the address window, fans out per-lane clock-enable and write-enable, and absorbs the BRAM's one-cycle unregistered read latency. It produces a single-cycle mem_ready pulse per transfer.

---
 rtl/sysmem_pkg.sv | 20 ++
 rtl/sysmem_bus_ctrl.sv | 82 ++++++++
 2 files changed

// File: rtl/sysmem_pkg.sv
// Shared definitions for the system-memory bus bridge: FSM encoding and the
// byte-lane layout of the four lane BRAMs.
package sysmem_pkg;

    localparam int unsigned SYSMEM_LANES  = 4;
    localparam int unsigned SYSMEM_LANE_W = 8;
    localparam int unsigned SYSMEM_DATA_W = SYSMEM_LANES * SYSMEM_LANE_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_CAP = 2'd1,
        ST_ACK    = 2'd2
    } sysmem_state_e;

    // Lane n carries data bits [lane_lsb(n) +: SYSMEM_LANE_W].
    function automatic int unsigned lane_lsb(input int unsigned lane);
        return lane * SYSMEM_LANE_W;
    endfunction

endpackage

// File: rtl/sysmem_bus_ctrl.sv
// PicoRV32 native-bus bridge to the four byte-lane system-memory BRAMs:
// window decode, per-lane enables and capture of the one-cycle read latency.
module sysmem_bus_ctrl
    import sysmem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clka,
    input  logic                     rsta,
    input  logic                     mem_valid,
    input  logic [31:0]              mem_addr,
    input  logic [SYSMEM_DATA_W-1:0] mem_wdata,
    input  logic [SYSMEM_LANES-1:0]  mem_wstrb,
    output logic                     mem_ready,
    output logic [SYSMEM_DATA_W-1:0] mem_rdata,
    output logic                     sel,
    output logic [ADDR_W-1:0]        bram_addr,
    output logic [SYSMEM_LANES-1:0]  bram_ce,
    output logic [SYSMEM_LANES-1:0]  bram_we,
    output logic [SYSMEM_DATA_W-1:0] bram_din,
    input  logic [SYSMEM_DATA_W-1:0] bram_dout
);

    localparam int unsigned TAG_LSB = ADDR_W + 2;

    sysmem_state_e              state_q, state_d;
    logic                       ready_q, ready_d;
    logic [SYSMEM_DATA_W-1:0]   rdata_q, rdata_d;
    logic                       unused_byte_offset;

    // Byte offset within the word plays no part in the lane access.
    assign unused_byte_offset = ^mem_addr[1:0];

    assign sel       = mem_valid && (mem_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    assign bram_addr = mem_addr[TAG_LSB-1:2];
    assign bram_din  = mem_wdata;
    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    // BRAM strobes only ever fire from IDLE, so ACK can never re-trigger an access.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        bram_ce = '0;
        bram_we = '0;
        case (state_q)
            ST_IDLE: begin
                if (sel && !rsta) begin
                    if (|mem_wstrb) begin
                        bram_ce = mem_wstrb;
                        bram_we = mem_wstrb;
                        state_d = ST_ACK;
                    end else begin
                        bram_ce = '1;
                        state_d = ST_RD_CAP;
                    end
                end
            end
            ST_RD_CAP: begin
                rdata_d = bram_dout;
                state_d = ST_ACK;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_ACK);
    end

endmodule
